// File: rtl/mem_wb_pipe.sv
// Stallable, flushable MEM/WB pipeline register chain with per-slot valid bits.
// Optional perf counters enabled by defining MEM_WB_PIPE_PERF_EN.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DST_W  = 5,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DST_W-1:0]  dst_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DST_W-1:0]  dst_o,
  output logic              busy_o
`ifdef MEM_WB_PIPE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("mem_wb_pipe: STAGES must be in 1..4");
  end

  logic [STAGES-1:0]             valid_q, valid_d, sh_valid;
  logic [STAGES-1:0][CTRL_W-1:0] ctrl_q,  ctrl_d,  sh_ctrl;
  logic [STAGES-1:0][DATA_W-1:0] data_q,  data_d,  sh_data;
  logic [STAGES-1:0][DST_W-1:0]  dst_q,   dst_d,   sh_dst;

  // Shifted-in view of the chain; a bubble never carries live control bits.
  assign sh_valid[0] = valid_i;
  assign sh_ctrl[0]  = valid_i ? ctrl_i : '0;
  assign sh_data[0]  = data_i;
  assign sh_dst[0]   = dst_i;

  for (genvar k = 1; k < STAGES; k++) begin : g_shift
    assign sh_valid[k] = valid_q[k-1];
    assign sh_ctrl[k]  = ctrl_q[k-1];
    assign sh_data[k]  = data_q[k-1];
    assign sh_dst[k]   = dst_q[k-1];
  end

  // Flush kills valid/ctrl but keeps data/dst; stall holds everything.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    dst_d   = dst_q;
    if (flush_i) begin
      valid_d = '0;
      ctrl_d  = '0;
    end else if (!stall_i) begin
      valid_d = sh_valid;
      ctrl_d  = sh_ctrl;
      data_d  = sh_data;
      dst_d   = sh_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
      dst_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      dst_q   <= dst_d;
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign ctrl_o  = ctrl_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];
  assign dst_o   = dst_q[STAGES-1];
  assign busy_o  = |valid_q;

`ifdef MEM_WB_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counters wrap naturally at 32 bits.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!flush_i && stall_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!flush_i && !stall_i && !valid_i) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe (STAGES=2): directed scenarios plus a randomized run
// against a queue-based reference model of the slot chain.
module tb_mem_wb_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned DST_W  = 5;
  localparam int unsigned STAGES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i, flush_i, valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic [DST_W-1:0]  dst_i;
  logic              valid_o, busy_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [DST_W-1:0]  dst_o;
`ifdef MEM_WB_PIPE_PERF_EN
  logic [31:0]       stall_cnt_o, bubble_cnt_o;
  logic [31:0]       m_stall_cnt, m_bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  mem_wb_pipe #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .DST_W(DST_W), .STAGES(STAGES)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i), .dst_i(dst_i),
    .valid_o(valid_o), .ctrl_o(ctrl_o), .data_o(data_o), .dst_o(dst_o),
    .busy_o(busy_o)
`ifdef MEM_WB_PIPE_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of in-flight instructions, newest at the front.
  typedef struct {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [DST_W-1:0]  dst;
  } slot_t;

  slot_t mq[$];

  always @(posedge clk) begin
    slot_t s;
    if (rst) begin
      foreach (mq[i]) mq[i] = '{1'b0, '0, '0, '0};
    end else if (flush_i) begin
      foreach (mq[i]) begin
        mq[i].valid = 1'b0;
        mq[i].ctrl  = '0;
      end
    end else if (!stall_i) begin
      s.valid = valid_i;
      s.ctrl  = valid_i ? ctrl_i : '0;
      s.data  = data_i;
      s.dst   = dst_i;
      mq.push_front(s);
      void'(mq.pop_back());
    end
`ifdef MEM_WB_PIPE_PERF_EN
    if (rst) begin
      m_stall_cnt  = 0;
      m_bubble_cnt = 0;
    end else if (!flush_i && stall_i) begin
      m_stall_cnt = m_stall_cnt + 1;
    end else if (!flush_i && !valid_i) begin
      m_bubble_cnt = m_bubble_cnt + 1;
    end
`endif
  end

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic [DST_W-1:0] ds, input logic st, input logic fl);
    valid_i = v; ctrl_i = c; data_i = d; dst_i = ds; stall_i = st; flush_i = fl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b11, 32'h1234_5678, 5'd31, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (valid_o !== 1'b0 || ctrl_o !== 2'b00 || data_o !== 32'h0 || dst_o !== 5'd0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got v=%b c=%b d=%h dst=%0d busy=%b, want all zero",
                 i, valid_o, ctrl_o, data_o, dst_o, busy_o);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    drive(1'b1, 2'b01, 32'hDEAD_BEEF, 5'd7, 1'b0, 1'b0);
    step();
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_c1: got v=%b busy=%b, want v=0 busy=1", valid_o, busy_o);
    end
    drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    checks++;
    if (valid_o !== 1'b1 || ctrl_o !== 2'b01 || data_o !== 32'hDEAD_BEEF || dst_o !== 5'd7 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_c2: got v=%b c=%b d=%h dst=%0d busy=%b, want 1 01 deadbeef 7 1",
               valid_o, ctrl_o, data_o, dst_o, busy_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0 || ctrl_o !== 2'b00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_c3: got v=%b c=%b busy=%b, want 0 00 0", valid_o, ctrl_o, busy_o);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 2'b01, 32'h1, 5'd1, 1'b0, 1'b0);
    step();
    drive(1'b0, 2'b00, 32'hAA, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b11, 32'hB, 5'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid_o !== 1'b1 || ctrl_o !== 2'b01 || data_o !== 32'h1 || dst_o !== 5'd1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b c=%b d=%h dst=%0d, want 1 01 1 1",
                 i, valid_o, ctrl_o, data_o, dst_o);
      end
    end
    drive(1'b0, 2'b00, 32'hCC, 5'd0, 1'b0, 1'b0);
    step();
    checks++;
    if (valid_o !== 1'b0 || data_o !== 32'hAA) begin
      errors++;
      $display("FAIL stall_resume1: got v=%b d=%h, want v=0 d=aa", valid_o, data_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0 || data_o !== 32'hCC || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume2: got v=%b d=%h busy=%b, want v=0 d=cc busy=0", valid_o, data_o, busy_o);
    end
  endtask

  task automatic test_flush_over_stall();
    drive(1'b1, 2'b01, 32'h10, 5'd3, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b10, 32'h20, 5'd4, 1'b0, 1'b0);
    step();
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'h10 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: got v=%b d=%h busy=%b, want 1 10 1", valid_o, data_o, busy_o);
    end
    drive(1'b1, 2'b11, 32'h30, 5'd5, 1'b1, 1'b1);
    step();
    checks++;
    if (valid_o !== 1'b0 || ctrl_o !== 2'b00 || busy_o !== 1'b0 || data_o !== 32'h10 || dst_o !== 5'd3) begin
      errors++;
      $display("FAIL flush_post: got v=%b c=%b busy=%b d=%h dst=%0d, want 0 00 0 10 3",
               valid_o, ctrl_o, busy_o, data_o, dst_o);
    end
    drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    checks++;
    if (data_o !== 32'h20 || valid_o !== 1'b0 || ctrl_o !== 2'b00) begin
      errors++;
      $display("FAIL flush_keep_data: got v=%b c=%b d=%h, want 0 00 20", valid_o, ctrl_o, data_o);
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 2'b11, 32'h55, 5'd9, 1'b0, 1'b0);
    step();
    drive(1'b0, 2'b11, 32'h66, 5'd10, 1'b0, 1'b0);
    step();
    checks++;
    if (valid_o !== 1'b0 || ctrl_o !== 2'b00 || data_o !== 32'h55 || dst_o !== 5'd9) begin
      errors++;
      $display("FAIL bubble: got v=%b c=%b d=%h dst=%0d, want 0 00 55 9", valid_o, ctrl_o, data_o, dst_o);
    end
  endtask

`ifdef MEM_WB_PIPE_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b1, 2'b01, 32'h7, 5'd1, 1'b1, 1'b0);
    repeat (3) step();
    drive(1'b0, 2'b11, 32'h8, 5'd2, 1'b0, 1'b0);
    repeat (4) step();
    checks++;
    if (stall_cnt_o !== 32'd3 || bubble_cnt_o !== 32'd4) begin
      errors++;
      $display("FAIL perf_counts: got stall=%0d bubble=%0d, want 3 4", stall_cnt_o, bubble_cnt_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (stall_cnt_o !== 32'd0 || bubble_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got stall=%0d bubble=%0d, want 0 0", stall_cnt_o, bubble_cnt_o);
    end
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    release dut.stall_cnt_q;
    m_stall_cnt = 32'hFFFF_FFFF;
    drive(1'b1, 2'b01, 32'h9, 5'd3, 1'b1, 1'b0);
    step();
    checks++;
    if (stall_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL perf_wrap: got stall=%h, want 00000000", stall_cnt_o);
    end
  endtask
`endif

  task automatic test_random();
    slot_t e;
    logic  exp_busy;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) < 3);
      drive(1'($urandom_range(0, 99) < 70), CTRL_W'($urandom), DATA_W'($urandom), DST_W'($urandom),
            1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 10));
      step();
      e = mq[STAGES-1];
      exp_busy = 1'b0;
      foreach (mq[i]) exp_busy = exp_busy | mq[i].valid;
      checks++;
      if (valid_o !== e.valid || ctrl_o !== e.ctrl || data_o !== e.data || dst_o !== e.dst || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b c=%b d=%h dst=%0d busy=%b, want v=%b c=%b d=%h dst=%0d busy=%b",
                 n, valid_o, ctrl_o, data_o, dst_o, busy_o, e.valid, e.ctrl, e.data, e.dst, exp_busy);
      end
`ifdef MEM_WB_PIPE_PERF_EN
      checks++;
      if (stall_cnt_o !== m_stall_cnt || bubble_cnt_o !== m_bubble_cnt) begin
        errors++;
        $display("FAIL random_perf[%0d]: got stall=%0d bubble=%0d, want %0d %0d",
                 n, stall_cnt_o, bubble_cnt_o, m_stall_cnt, m_bubble_cnt);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(STAGES); i++) mq.push_back('{1'b0, '0, '0, '0});
`ifdef MEM_WB_PIPE_PERF_EN
    m_stall_cnt  = 0;
    m_bubble_cnt = 0;
`endif
    rst = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_latency();
    test_stall();
    test_flush_over_stall();
    test_bubble();
`ifdef MEM_WB_PIPE_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
